// File: rtl/spi_multi_adc_reader.sv
// ---------------------------------------------------------------------------
// spi_multi_adc_reader
//
// Purpose:
//   Starts a conversion on a bank of SPI ADCs that share CONVST and BUSY.
//   It waits for the BUSY handshake, then reads one frame from each enabled
//   ADC in turn, lowest index first, over a shared SCLK. Each ADC has its
//   own chip select and DOUT line. All frames are presented together on
//   o_Data with a single o_Valid pulse.
//
// Ports:
//   i_Clk        sole clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_START      request one conversion-and-read sequence (accepted in IDLE)
//   i_CHAN_MASK  per-ADC read enable, latched when START is accepted
//   i_BUSY       shared ADC BUSY line, high while converting
//   i_DOUT       serial data, bit k from ADC k
//   o_SCLK       SPI clock, idles low
//   o_CONVST     conversion start, active low
//   o_CS         chip selects, active low, at most one low at a time
//   o_Data       frame of ADC k at [k*FRAME_BITS +: FRAME_BITS], MSB first
//   o_Valid      one-cycle pulse when o_Data updates
//   o_Busy       high whenever the FSM is not IDLE
//   o_Error      one-cycle pulse on BUSY watchdog timeout
//
// Optional feature:
//   SPI_ADC_TIMEOUT_EN  when defined, a watchdog bounds the BUSY wait.
//                       Otherwise the wait is unbounded and o_Error is tied 0.
// ---------------------------------------------------------------------------
module spi_multi_adc_reader #(
    parameter int NUM_ADC           = 2,
    parameter int FRAME_BITS        = 128,
    parameter int CLK_DIV           = 5,
    parameter int CONVST_LOW_CYCLES = 2,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic                          i_START,
    input  logic [NUM_ADC-1:0]            i_CHAN_MASK,
    input  logic                          i_BUSY,
    input  logic [NUM_ADC-1:0]            i_DOUT,
    output logic                          o_SCLK,
    output logic                          o_CONVST,
    output logic [NUM_ADC-1:0]            o_CS,
    output logic [NUM_ADC*FRAME_BITS-1:0] o_Data,
    output logic                          o_Valid,
    output logic                          o_Busy,
    output logic                          o_Error
);

    localparam int SEL_W = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNV_W = (CONVST_LOW_CYCLES > 1) ? $clog2(CONVST_LOW_CYCLES) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int IDX_W = $clog2(NUM_ADC * FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_WAIT_BUSY_HIGH,
        S_WAIT_BUSY_LOW,
        S_SELECT,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                          r_State;
    state_t                          w_NextState;

    logic [NUM_ADC-1:0]              r_Mask;
    logic [NUM_ADC-1:0]              r_ReadDone;
    logic [SEL_W-1:0]                r_Sel;
    logic [DIV_W-1:0]                r_Div;
    logic [CNV_W-1:0]                r_ConvCnt;
    // Bits still to capture in the current frame; 0 means the last rising
    // edge has happened and the next SCLK fall closes the frame.
    logic [BIT_W-1:0]                r_BitCnt;
    logic [NUM_ADC*FRAME_BITS-1:0]   r_Shadow;
    logic [NUM_ADC*FRAME_BITS-1:0]   r_Data;
    logic                            r_Valid;
    logic                            r_SCLK;
    logic                            r_CONVST;
    logic [NUM_ADC-1:0]              r_CS;

    logic [NUM_ADC-1:0]              w_Pending;
    logic                            w_AnyPending;
    logic [SEL_W-1:0]                w_NextSel;
    logic [NUM_ADC*FRAME_BITS-1:0]   w_MaskBits;
    logic [IDX_W-1:0]                w_BitIdx;
    logic                            w_DivTick;
    logic                            w_ConvEnd;
    logic                            w_Timeout;

`ifdef SPI_ADC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]                 r_ToCnt;
    logic                            r_Error;
`endif

    // ------------------------------------------------------------------
    // Next-state and decode logic
    // ------------------------------------------------------------------
    always_comb begin
        w_NextState  = r_State;
        w_Pending    = r_Mask & ~r_ReadDone;
        w_AnyPending = |w_Pending;
        w_NextSel    = '0;
        w_MaskBits   = '0;
        w_DivTick    = (r_Div == DIV_W'(CLK_DIV - 1));
        w_ConvEnd    = (r_ConvCnt == CNV_W'(CONVST_LOW_CYCLES - 1));
        w_BitIdx     = IDX_W'(int'(r_Sel) * FRAME_BITS + int'(r_BitCnt) - 1);
        w_Timeout    = 1'b0;

        // Descending scan so the lowest pending index wins.
        for (int k = NUM_ADC - 1; k >= 0; k--) begin
            if (w_Pending[k]) w_NextSel = SEL_W'(k);
        end
        for (int k = 0; k < NUM_ADC; k++) begin
            w_MaskBits[k*FRAME_BITS +: FRAME_BITS] = {FRAME_BITS{r_Mask[k]}};
        end

`ifdef SPI_ADC_TIMEOUT_EN
        // Handshake progress in the final cycle takes priority over the timeout.
        w_Timeout = (((r_State == S_WAIT_BUSY_HIGH) && !i_BUSY) ||
                     ((r_State == S_WAIT_BUSY_LOW)  &&  i_BUSY)) &&
                    (r_ToCnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

        case (r_State)
            S_IDLE:           if (i_START) w_NextState = S_CONVST;
            S_CONVST:         if (w_ConvEnd) w_NextState = i_BUSY ? S_WAIT_BUSY_LOW : S_WAIT_BUSY_HIGH;
            S_WAIT_BUSY_HIGH: if (i_BUSY) w_NextState = S_WAIT_BUSY_LOW;
            S_WAIT_BUSY_LOW:  if (!i_BUSY) w_NextState = S_SELECT;
            S_SELECT:         w_NextState = w_AnyPending ? S_SHIFT : S_DONE;
            S_SHIFT:          if (w_DivTick && r_SCLK && (r_BitCnt == '0)) w_NextState = S_GAP;
            S_GAP:            w_NextState = S_SELECT;
            S_DONE:           w_NextState = S_IDLE;
            default:          w_NextState = S_IDLE;
        endcase

        if (w_Timeout) w_NextState = S_IDLE;
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State    <= S_IDLE;
            r_Mask     <= '0;
            r_ReadDone <= '0;
            r_Sel      <= '0;
            r_Div      <= '0;
            r_ConvCnt  <= '0;
            r_BitCnt   <= '0;
            r_Shadow   <= '0;
            r_Data     <= '0;
            r_Valid    <= 1'b0;
            r_SCLK     <= 1'b0;
            r_CONVST   <= 1'b1;
            r_CS       <= '1;
        end else begin
            r_State <= w_NextState;
            r_Valid <= 1'b0;

            case (r_State)
                S_IDLE: begin
                    if (i_START) begin
                        r_Mask     <= i_CHAN_MASK;
                        r_ReadDone <= '0;
                        r_ConvCnt  <= '0;
                        r_CONVST   <= 1'b0;
                    end
                end
                S_CONVST: begin
                    if (w_ConvEnd) r_CONVST  <= 1'b1;
                    else           r_ConvCnt <= r_ConvCnt + 1'b1;
                end
                S_SELECT: begin
                    r_Div    <= '0;
                    r_BitCnt <= BIT_W'(FRAME_BITS);
                    if (w_AnyPending) begin
                        r_Sel                 <= w_NextSel;
                        r_ReadDone[w_NextSel] <= 1'b1;
                        r_CS[w_NextSel]       <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (w_DivTick) begin
                        r_Div <= '0;
                        if (!r_SCLK) begin
                            // Rising edge: capture the selected DOUT, MSB first.
                            r_SCLK             <= 1'b1;
                            r_Shadow[w_BitIdx] <= i_DOUT[r_Sel];
                            r_BitCnt           <= r_BitCnt - 1'b1;
                        end else begin
                            // Falling edge; after the last bit it also ends the frame.
                            r_SCLK <= 1'b0;
                            if (r_BitCnt == '0) r_CS <= '1;
                        end
                    end else begin
                        r_Div <= r_Div + 1'b1;
                    end
                end
                S_DONE: begin
                    r_Data  <= r_Shadow & w_MaskBits;
                    r_Valid <= 1'b1;
                end
                default: ;
            endcase

            if (w_Timeout) r_CS <= '1;
        end
    end

`ifdef SPI_ADC_TIMEOUT_EN
    // ------------------------------------------------------------------
    // BUSY watchdog, running across both wait states
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_ToCnt <= '0;
            r_Error <= 1'b0;
        end else begin
            r_Error <= w_Timeout;
            if ((r_State == S_WAIT_BUSY_HIGH) || (r_State == S_WAIT_BUSY_LOW))
                r_ToCnt <= r_ToCnt + 1'b1;
            else
                r_ToCnt <= '0;
        end
    end
    assign o_Error = r_Error;
`else
    assign o_Error = 1'b0;
`endif

    assign o_SCLK   = r_SCLK;
    assign o_CONVST = r_CONVST;
    assign o_CS     = r_CS;
    assign o_Data   = r_Data;
    assign o_Valid  = r_Valid;
    assign o_Busy   = (r_State != S_IDLE);

endmodule

// File: doc/spi_multi_adc_reader.md
SPI_MULTI_ADC_READER -- requirements
Module: spi_multi_adc_reader

Interface
REQ-001 SHALL have parameter NUM_ADC, default 2, meaning the number of ADC devices with one CS and one DOUT line each (range 1..8).
REQ-002 SHALL have parameter FRAME_BITS, default 128, meaning the bits read per ADC frame (range 8..256).
REQ-003 SHALL have parameter CLK_DIV, default 5, meaning the SCLK half-period in i_Clk cycles (minimum 1).
REQ-004 SHALL have parameter CONVST_LOW_CYCLES, default 2, meaning the CONVST low pulse width in i_Clk cycles (minimum 1).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the BUSY watchdog limit in i_Clk cycles.
REQ-006 i_Clk  input  1  sole clock; all logic on its rising edge.
REQ-007 i_Reset  input  1  synchronous, active-high reset.
REQ-008 i_START  input  1  request one conversion-and-read sequence.
REQ-009 i_CHAN_MASK  input  NUM_ADC  per-ADC read enable; sampled when START is accepted.
REQ-010 i_BUSY  input  1  shared ADC BUSY line, high while converting.
REQ-011 i_DOUT  input  NUM_ADC  serial data, bit k from ADC k.
REQ-012 o_SCLK  output  1  SPI clock; idles low.
REQ-013 o_CONVST  output  1  conversion start, active low.
REQ-014 o_CS  output  NUM_ADC  chip selects, active low, at most one low at any time.
REQ-015 o_Data  output  NUM_ADC*FRAME_BITS  frame of ADC k at bits [k*FRAME_BITS +: FRAME_BITS], MSB first.
REQ-016 o_Valid  output  1  one-cycle pulse when o_Data updates.
REQ-017 o_Busy  output  1  high whenever the FSM is not IDLE.
REQ-018 o_Error  output  1  one-cycle pulse on BUSY timeout.

Function
REQ-019 FSM states SHALL be IDLE, CONVST, WAIT_BUSY_HIGH, WAIT_BUSY_LOW, SELECT, SHIFT, GAP, DONE.
REQ-020 In IDLE with i_START=1, the block SHALL latch i_CHAN_MASK, drive o_CONVST low on the next cycle, and enter CONVST.
REQ-021 i_START SHALL be ignored in every state except IDLE.
REQ-022 CONVST SHALL hold o_CONVST low for exactly CONVST_LOW_CYCLES cycles, then drive it high and enter WAIT_BUSY_LOW if i_BUSY=1, otherwise WAIT_BUSY_HIGH.
REQ-023 WAIT_BUSY_HIGH SHALL go to WAIT_BUSY_LOW on i_BUSY=1.
REQ-024 WAIT_BUSY_LOW SHALL go to SELECT on i_BUSY=0.
REQ-025 SELECT SHALL pick the lowest-index enabled ADC not yet read, drive its o_CS low, and enter SHIFT; if no ADC remains, it SHALL enter DONE.
REQ-026 In SHIFT, o_SCLK SHALL toggle every CLK_DIV cycles starting low, giving FRAME_BITS rising edges.
REQ-027 On each rising edge, the block SHALL capture the selected i_DOUT bit into a shadow register, index FRAME_BITS-1 first down to 0.
REQ-028 After the final rising edge, the block SHALL hold o_SCLK high for CLK_DIV cycles, drive it low, drive all o_CS high, and enter GAP.
REQ-029 GAP SHALL last exactly one cycle with all o_CS high, then return to SELECT.
REQ-030 DONE SHALL copy the shadow registers to o_Data, clearing slices of masked ADCs to zero, pulse o_Valid for one cycle, and return to IDLE.
REQ-031 o_Data SHALL change only in DONE, never mid-sequence.
REQ-032 With a latched mask of all zeros, the block SHALL still run the conversion, skip SELECT reads, pulse o_Valid, and set o_Data to all zeros.
REQ-033 o_SCLK SHALL stay low in every state other than SHIFT.

Reset
REQ-034 i_Reset=1 SHALL, on the next edge and in any state including mid-SHIFT, force IDLE, o_CONVST=1, o_CS all 1, o_SCLK=0, o_Data=0, o_Valid=0, o_Busy=0, o_Error=0, and clear the divider, bit counter, and shadow registers.
REQ-035 Reset SHALL take priority over i_START in the same cycle.

Configuration
REQ-036 With macro SPI_ADC_TIMEOUT_EN defined, a counter SHALL run across WAIT_BUSY_HIGH and WAIT_BUSY_LOW; on reaching TIMEOUT_CYCLES the block SHALL pulse o_Error, drive o_CS all high, return to IDLE, leave o_Data unchanged, and not pulse o_Valid.
REQ-037 Without SPI_ADC_TIMEOUT_EN, BUSY waits SHALL be unbounded, o_Error SHALL be constant 0, and no timeout counter SHALL be synthesised.

Verification
REQ-038 NUM_ADC=2, FRAME_BITS=16, CLK_DIV=2, mask=2'b11, ADC0 sends 0xA5C3, ADC1 sends 0x3C5A -> o_Data=0x3C5A_A5C3, o_Valid pulses once, each CS is low for exactly 16 SCLK rising edges, 1-cycle GAP between selects.
REQ-039 Same configuration, mask=2'b10, ADC1 sends 0xFFFF -> only o_CS[1] toggles, o_Data=0xFFFF_0000.
REQ-040 mask=2'b00 -> CONVST pulse and BUSY handshake occur, no CS low, no SCLK edge, o_Valid pulses, o_Data=0.
REQ-041 i_Reset asserted at the 7th SCLK rise of ADC0 -> the next cycle shows IDLE outputs per REQ-034; a following START completes normally.
REQ-042 SPI_ADC_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, BUSY held high -> o_Error pulses 100 cycles after WAIT_BUSY entry, o_Valid stays 0, o_Data is unchanged.
REQ-043 i_START held high continuously -> back-to-back sequences, with START ignored while o_Busy=1 and exactly one o_Valid per sequence.
